axil_mem_arbiter: RTL

Round-robin arbiter that shares one single-port 32-bit config memory between num_req_p AXI-Lite-to-memory front ends. Each requester presents a level-held read or write request and receives a one-cycle done pulse plus read data. The arbiter serializes requests, drives the memory strobes, waits for the memory's done pulse, and returns the result to the granted requester. It sits between the per-host AXIL bridges and the shared config/CSR memory.

---
 rtl/axil_mem_arbiter.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/axil_mem_arbiter.sv
// Round-robin arbiter sharing one single-port 32-bit config memory.
// Optional BUSY timeout abort: define AXIL_MEM_ARB_TIMEOUT_EN.
module axil_mem_arbiter #(
  parameter int num_req_p        = 2,
  parameter int mem_addr_width_p = 8,
  parameter int timeout_cycles_p = 64
) (
  input  logic                                  clk_i,
  input  logic                                  reset_i,
  input  logic [num_req_p*mem_addr_width_p-1:0] req_addr_i,
  input  logic [num_req_p-1:0]                  req_wen_i,
  input  logic [num_req_p-1:0]                  req_ren_i,
  input  logic [num_req_p*32-1:0]               req_data_i,
  output logic [31:0]                           req_data_o,
  output logic [num_req_p-1:0]                  req_done_o,
  output logic [num_req_p-1:0]                  req_err_o,
  output logic [mem_addr_width_p-1:0]           mem_addr_o,
  output logic                                  mem_wen_o,
  output logic                                  mem_ren_o,
  output logic [31:0]                           mem_data_o,
  input  logic [31:0]                           mem_data_i,
  input  logic                                  mem_done_i
);

  localparam int idx_w_lp = (num_req_p > 1) ? $clog2(num_req_p) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } state_e;

  state_e                      state_q, state_n;
  logic [idx_w_lp-1:0]         ptr_q;
  logic [idx_w_lp-1:0]         grant_q;
  logic [idx_w_lp-1:0]         sel;
  logic                        found;
  logic [num_req_p-1:0]        pend;
  logic [mem_addr_width_p-1:0] addr_q;
  logic [31:0]                 wdata_q;
  logic [31:0]                 rdata_q;
  logic                        wr_q;
  logic                        err_q;
  logic                        timed_out;

  assign pend = req_wen_i | req_ren_i;

  // First pending requester at or after the pointer, cyclically.
  always_comb begin : arb
    int j;
    found = 1'b0;
    sel   = ptr_q;
    j     = 0;
    for (int i = 0; i < num_req_p; i++) begin
      j = int'(ptr_q) + i;
      if (j >= num_req_p) j = j - num_req_p;
      if (!found && pend[j]) begin
        found = 1'b1;
        sel   = idx_w_lp'(j);
      end
    end
  end

`ifdef AXIL_MEM_ARB_TIMEOUT_EN
  localparam int cnt_w_lp = $clog2(timeout_cycles_p + 1);

  logic [cnt_w_lp-1:0] cnt_q;

  // Counter is held at zero outside BUSY, so every BUSY entry starts clean.
  always_ff @(posedge clk_i) begin
    if (reset_i || state_q != BUSY) cnt_q <= '0;
    else                            cnt_q <= cnt_q + 1'b1;
  end

  assign timed_out = (state_q == BUSY) && !mem_done_i &&
                     (cnt_q == cnt_w_lp'(timeout_cycles_p - 1));
`else
  logic unused_timeout;

  assign unused_timeout = (timeout_cycles_p != 0);
  assign timed_out      = 1'b0;
`endif

  always_ff @(posedge clk_i) begin
    if (reset_i) state_q <= IDLE;
    else         state_q <= state_n;
  end

  always_comb begin
    state_n = state_q;
    unique case (state_q)
      IDLE:    if (found) state_n = BUSY;
      BUSY:    if (mem_done_i || timed_out) state_n = RESP;
      RESP:    state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q   <= '0;
      grant_q <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (found) begin
            grant_q <= sel;
            addr_q  <= req_addr_i[int'(sel)*mem_addr_width_p +: mem_addr_width_p];
            wdata_q <= req_data_i[int'(sel)*32 +: 32];
            wr_q    <= req_wen_i[sel];
            err_q   <= req_wen_i[sel] & req_ren_i[sel];
          end
        end
        BUSY: begin
          if (mem_done_i) begin
            if (!wr_q) rdata_q <= mem_data_i;
          end else if (timed_out) begin
            rdata_q <= 32'hdead_beef;
            err_q   <= 1'b1;
          end
        end
        RESP: begin
          if (grant_q == idx_w_lp'(num_req_p - 1)) ptr_q <= '0;
          else                                     ptr_q <= grant_q + 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign mem_wen_o  = (state_q == BUSY) &  wr_q;
  assign mem_ren_o  = (state_q == BUSY) & ~wr_q;
  assign mem_addr_o = addr_q;
  assign mem_data_o = wdata_q;
  assign req_data_o = rdata_q;

  always_comb begin
    req_done_o = '0;
    req_err_o  = '0;
    if (state_q == RESP) begin
      req_done_o[grant_q] = 1'b1;
      req_err_o[grant_q]  = err_q;
    end
  end

endmodule
